// File: rtl/fifo_gen_pkg.sv
// Shared types and constants for the FIFO traffic generator.
package fifo_gen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrain,
    StRandom,
    StFlush,
    StDone
  } gen_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] DEFAULT_WR_THRESH = 8'd179;
  localparam logic [7:0] DEFAULT_RD_THRESH = 8'd77;

  // Extra edges allowed beyond FIFO_DEPTH before a phase is declared stuck.
  localparam int unsigned TIMEOUT_MARGIN = 4;

endpackage

// File: rtl/fifo_gen_lfsr.sv
// 16-bit Galois LFSR with enable; reloads SEED on reset.
module fifo_gen_lfsr
  import fifo_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  // Shift right, folding the taps in when a one falls out of the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/fifo_traffic_gen.sv
// Stimulus source for a FIFO: fill/overflow probe, drain/underflow probe,
// LFSR-driven mixed traffic, then flush. Reports counters and sticky flags.
// Optional macro FIFO_GEN_DATA_CHECK_EN adds XOR checksums of written vs read
// data, compared on reaching DONE.
module fifo_traffic_gen
  import fifo_gen_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_OPS    = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [7:0]  WR_THRESH  = DEFAULT_WR_THRESH,
  parameter logic [7:0]  RD_THRESH  = DEFAULT_RD_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count,
  output logic                  ovf_seen,
  output logic                  udf_seen,
  output logic                  timeout_err,
  output logic                  chk_err
);

  localparam int unsigned PhaseLimit = FIFO_DEPTH + TIMEOUT_MARGIN;

  gen_state_e            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d, cnt_inc;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tmo_q, tmo_d;
  logic [31:0]           wr_cnt_q, rd_cnt_q;
  logic                  ovf_q, udf_q;
  logic [15:0]           lfsr;
  logic                  lfsr_en;
  logic                  rd_acc;
  // Older words shift up so wide buses carry successive LFSR values.
  logic [FIFO_WIDTH+15:0] data_cat;

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign lfsr_en  = busy;
  assign rd_acc   = rd_en_q & ~empty;
  assign cnt_inc  = cnt_q + 32'd1;
  assign data_cat = {data_q, lfsr};

  fifo_gen_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .value (lfsr)
  );

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      tmo_q   <= tmo_d;
    end
  end

  // Phase sequencing; requests are registered so the FIFO sees them one edge later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wr_en_d = wr_en_q;
    rd_en_d = rd_en_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          cnt_d   = '0;
          wr_en_d = 1'b1;
          rd_en_d = 1'b0;
        end
      end
      StFill: begin
        data_d = data_cat[FIFO_WIDTH-1:0];
        cnt_d  = cnt_inc;
        if (full) begin
          // The write already in flight becomes the overflow probe.
          state_d = StDrain;
          cnt_d   = '0;
          wr_en_d = 1'b0;
          rd_en_d = 1'b1;
        end else if (cnt_inc > PhaseLimit) begin
          state_d = StDone;
          tmo_d   = 1'b1;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
        end
      end
      StDrain: begin
        cnt_d = cnt_inc;
        if (empty) begin
          // The read already in flight becomes the underflow probe.
          state_d = StRandom;
          cnt_d   = '0;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
        end else if (cnt_inc > PhaseLimit) begin
          state_d = StDone;
          tmo_d   = 1'b1;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
        end
      end
      StRandom: begin
        data_d = data_cat[FIFO_WIDTH-1:0];
        cnt_d  = cnt_inc;
        if (cnt_inc >= NUM_OPS) begin
          state_d = StFlush;
          cnt_d   = '0;
          wr_en_d = 1'b0;
          rd_en_d = 1'b1;
        end else begin
          wr_en_d = (lfsr[7:0] < WR_THRESH);
          rd_en_d = (lfsr[15:8] < RD_THRESH);
        end
      end
      StFlush: begin
        cnt_d = cnt_inc;
        if (empty) begin
          state_d = StDone;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
        end else if (cnt_inc > PhaseLimit) begin
          state_d = StDone;
          tmo_d   = 1'b1;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
        end
      end
      StDone: begin
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating transfer counters and sticky protocol flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ack && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (rd_acc && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (overflow)  ovf_q <= 1'b1;
      if (underflow) udf_q <= 1'b1;
    end
  end

`ifdef FIFO_GEN_DATA_CHECK_EN
  logic [FIFO_WIDTH-1:0] sent_q, wr_sum_q, rd_sum_q;
  logic                  cap_q, chk_q;

  // wr_ack trails the write by one edge, so sent_q holds the word it acknowledges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q   <= '0;
      wr_sum_q <= '0;
      rd_sum_q <= '0;
      cap_q    <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      sent_q <= data_q;
      cap_q  <= rd_acc;
      if (wr_ack) wr_sum_q <= wr_sum_q ^ sent_q;
      if (cap_q)  rd_sum_q <= rd_sum_q ^ data_out;
      if ((state_q == StDone) && (wr_sum_q != rd_sum_q)) chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;
`else
  logic unused_data_out;
  assign unused_data_out = ^data_out;
  assign chk_err         = 1'b0;
`endif

  assign data_in     = data_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign wr_count    = wr_cnt_q;
  assign rd_count    = rd_cnt_q;
  assign ovf_seen    = ovf_q;
  assign udf_seen    = udf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench for fifo_traffic_gen: a behavioural FIFO on the far side of the
// interface, a table of phase checkpoints, and LFSR-sequence predictions.
module tb_fifo_traffic_gen;

  localparam int W         = 16;
  localparam int DEPTH     = 8;
  localparam int NOPS      = 1000;
  localparam int RND_FIRST = 19;          // first edge after start that issues random requests
  localparam int FLUSH_AT  = 18 + NOPS;   // edge after start that enters FLUSH
  localparam int NVEC      = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         kill_full = 1'b0;
  logic         corrupt_en = 1'b0;
  logic [W-1:0] corrupt = '0;

  logic         f_full, f_empty, f_ack, f_ovf, f_udf;
  logic [W-1:0] f_dout;
  logic [W-1:0] data_in;
  logic         wr_en, rd_en, busy, done, ovf_seen, udf_seen, timeout_err, chk_err;
  logic [31:0]  wr_count, rd_count;

  int checks = 0;
  int failures = 0;
  int j = 0;
  int run_kind = 0;  // 0: no per-cycle checks, 1: normal run, 2: forced-timeout run
  int acc_wr = 0;
  int acc_rd = 0;

  logic [15:0] lseq [0:NOPS+63];

  typedef struct {
    int          cyc;
    logic        busy, done, wr_en, rd_en, ovf, udf;
    logic [31:0] wrc, rdc;
  } vec_t;
  vec_t tv [NVEC];

  always #5 clk = ~clk;

  fifo_traffic_gen #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (DEPTH),
    .NUM_OPS    (NOPS),
    .LFSR_SEED  (16'hACE1),
    .WR_THRESH  (8'd179),
    .RD_THRESH  (8'd77)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .full        (f_full & ~kill_full),
    .empty       (f_empty),
    .wr_ack      (f_ack),
    .overflow    (f_ovf),
    .underflow   (f_udf),
    .data_out    (f_dout ^ corrupt),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count),
    .rd_count    (rd_count),
    .ovf_seen    (ovf_seen),
    .udf_seen    (udf_seen),
    .timeout_err (timeout_err),
    .chk_err     (chk_err)
  );

  // Reference FIFO with registered flags and a one-edge-late write acknowledge.
  logic [W-1:0] q [$];
  bit           fw, fr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      f_full  <= 1'b0;
      f_empty <= 1'b1;
      f_ack   <= 1'b0;
      f_ovf   <= 1'b0;
      f_udf   <= 1'b0;
      f_dout  <= '0;
      acc_wr = 0;
      acc_rd = 0;
    end else begin
      fw = wr_en && (q.size() < DEPTH);
      fr = rd_en && (q.size() > 0);
      f_ack <= fw;
      f_ovf <= wr_en && (q.size() == DEPTH);
      f_udf <= rd_en && (q.size() == 0);
      if (fr) begin
        f_dout <= q.pop_front();
        acc_rd++;
      end
      if (fw) begin
        q.push_back(data_in);
        acc_wr++;
      end
      f_full  <= (q.size() == DEPTH);
      f_empty <= (q.size() == 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t j=%0d)", name, act, exp, $time, j);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_in"}, 64'(data_in), 64'd0);
    check({tag, "_bits"}, 64'({wr_en, rd_en, busy, done, ovf_seen, udf_seen, timeout_err,
                               chk_err}), 64'd0);
    check({tag, "_wr_count"}, 64'(wr_count), 64'd0);
    check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
  endtask

  // One clock edge plus the per-cycle predictions derived from the LFSR sequence.
  task automatic step();
    logic ew, er;
    @(posedge clk);
    #1;
    j++;
    if (run_kind != 0 && j >= 1 && j <= 8) check("fill_data", 64'(data_in), 64'(lseq[j-1]));
    if (run_kind == 1) begin
      if (j >= 9 && j <= 18) check("drain_no_wr", 64'(wr_en), 64'd0);
      if (j == RND_FIRST) check("rnd_entry_udf_rd", 64'({udf_seen, rd_count}), {31'd0, 1'b1, 32'd8});
      if (j >= RND_FIRST && j < FLUSH_AT) begin
        ew = (lseq[j-1][7:0] < 8'd179);
        er = (lseq[j-1][15:8] < 8'd77);
        check("rnd_wr_en", 64'(wr_en), 64'(ew));
        check("rnd_rd_en", 64'(rd_en), 64'(er));
      end
      if (j == FLUSH_AT) check("flush_entry", 64'({wr_en, rd_en}), 64'd1);
      // Stray start pulses while running must be ignored.
      start   = ($urandom_range(0, 7) == 0);
      corrupt = (corrupt_en && j >= FLUSH_AT) ? 16'h0001 : 16'h0000;
    end
  endtask

  task automatic do_reset();
    run_kind   = 0;
    start      = 1'b0;
    corrupt_en = 1'b0;
    corrupt    = '0;
    kill_full  = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int kind);
    run_kind = 0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    j        = 0;
    run_kind = kind;
  endtask

  task automatic run_until(input int n);
    while (j < n) step();
  endtask

  task automatic do_table();
    for (int i = 0; i < NVEC; i++) begin
      run_until(tv[i].cyc);
      check($sformatf("vec%0d_flags", tv[i].cyc),
            64'({busy, done, wr_en, rd_en, ovf_seen, udf_seen}),
            64'({tv[i].busy, tv[i].done, tv[i].wr_en, tv[i].rd_en, tv[i].ovf, tv[i].udf}));
      check($sformatf("vec%0d_wr_count", tv[i].cyc), 64'(wr_count), 64'(tv[i].wrc));
      check($sformatf("vec%0d_rd_count", tv[i].cyc), 64'(rd_count), 64'(tv[i].rdc));
    end
  endtask

  task automatic end_checks(input logic exp_chk);
    for (int k = 0; k < 40 && done !== 1'b1; k++) step();
    check("done_reached", 64'(done), 64'd1);
    step();
    step();
    check("fin_busy_req", 64'({busy, wr_en, rd_en}), 64'd0);
    check("fin_wr_vs_model", 64'(wr_count), 64'(acc_wr));
    check("fin_rd_vs_model", 64'(rd_count), 64'(acc_rd));
    check("fin_wr_eq_rd", 64'(wr_count), 64'(rd_count));
    check("fin_timeout", 64'(timeout_err), 64'd0);
    check("fin_ovf_udf", 64'({ovf_seen, udf_seen}), 64'd3);
    check("fin_chk_err", 64'(chk_err), 64'(exp_chk));
  endtask

  initial begin
    int rj;
    lseq[0] = 16'hACE1;
    for (int k = 0; k < NOPS + 63; k++) begin
      lseq[k+1] = {1'b0, lseq[k][15:1]} ^ (lseq[k][0] ? 16'hB400 : 16'h0000);
    end
    //          cyc busy done wr rd ovf udf wrc    rdc
    tv[0] = '{0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    tv[1] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    tv[2] = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0};
    tv[3] = '{8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0};
    tv[4] = '{9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0};
    tv[5] = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8, 32'd1};
    tv[6] = '{17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8, 32'd8};
    tv[7] = '{18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8, 32'd8};

    #2;
    do_reset();
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;

    // Complete run from reset.
    do_start(1);
    do_table();
    run_until(FLUSH_AT);
    end_checks(1'b0);

    // FIFO never reports full: FILL must time out after 13 edges.
    do_reset();
    kill_full = 1'b1;
    do_start(2);
    run_until(12);
    check("tmo_before", 64'({busy, done, wr_en, rd_en, timeout_err}), 64'b10100);
    step();
    check("tmo_after", 64'({busy, done, wr_en, rd_en, timeout_err}), 64'b01001);
    step();
    check("tmo_done_holds", 64'({done, wr_en}), 64'b10);

    // Reset in the middle of RANDOM, then a fresh run repeats the same sequence.
    do_reset();
    do_start(1);
    do_table();
    rj = $urandom_range(30, 600);
    run_until(rj);
    do_reset();
    do_start(1);
    do_table();
    run_until(FLUSH_AT);
    end_checks(1'b0);

`ifdef FIFO_GEN_DATA_CHECK_EN
    // One flipped data_out bit during FLUSH must be caught by the checksum.
    do_reset();
    corrupt_en = 1'b1;
    do_start(1);
    do_table();
    run_until(FLUSH_AT);
    end_checks(1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
- Synthesizable stimulus source for the FIFO interface: drives data_in/wr_en/rd_en into the FIFO and consumes its status flags. It is the driving end of the interface that the FIFO monitor samples.
- Runs a fixed phase sequence on start: fill to full with an overflow probe, drain to empty with an underflow probe, a pseudo-random mixed phase, then a flush.
- Reports counters, sticky protocol flags and done, for on-chip self-test or a bench-less smoke run.

Parameters:
- FIFO_WIDTH, 16, data width of data_in/data_out
- FIFO_DEPTH, 8, FIFO entries; sizes timeouts
- NUM_OPS, 1000, cycles spent in RANDOM phase
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value
- WR_THRESH, 8'd179, write probability ~70% (lfsr[7:0] < WR_THRESH)
- RD_THRESH, 8'd77, read probability ~30% (lfsr[15:8] < RD_THRESH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- full  in  1  FIFO full flag
- empty  in  1  FIFO empty flag
- wr_ack  in  1  FIFO write accepted
- overflow  in  1  FIFO write rejected
- underflow  in  1  FIFO read on empty
- data_out  in  FIFO_WIDTH  FIFO read data; used only with the feature compiled in
- data_in  out  FIFO_WIDTH  write data
- wr_en  out  1  write request
- rd_en  out  1  read request
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- wr_count  out  32  count of cycles with wr_ack=1
- rd_count  out  32  count of accepted reads (rd_en=1 and empty=0 at the edge)
- ovf_seen  out  1  sticky: overflow observed
- udf_seen  out  1  sticky: underflow observed
- timeout_err  out  1  sticky: FILL, DRAIN or FLUSH exceeded its limit
- chk_err  out  1  sticky: checksum mismatch at DONE

Behaviour:
- Reset, asynchronous, rst_n low: state=IDLE; all outputs 0; LFSR=LFSR_SEED; phase counter=0.
- Registered outputs: a request set at edge k is seen by the FIFO at edge k+1. Flags are sampled as registered values.
- States: IDLE, FILL, DRAIN, RANDOM, FLUSH, DONE.
- IDLE: start=1 -> FILL with wr_en<=1. start is ignored in every other state.
- FILL: wr_en=1, rd_en=0. data_in<=lfsr[FIFO_WIDTH-1:0] on every edge.
  - Edge with full=1 -> DRAIN, wr_en<=0, rd_en<=1. The write already registered for that cycle is the overflow probe.
  - Phase counter > FIFO_DEPTH+4 -> timeout_err<=1, go to DONE.
- DRAIN: rd_en=1, wr_en=0.
  - Edge with empty=1 -> RANDOM, rd_en<=0. The read already registered is the underflow probe.
  - Same timeout rule as FILL.
- RANDOM: each edge, wr_en<=(lfsr[7:0]<WR_THRESH) and rd_en<=(lfsr[15:8]<RD_THRESH). Both may be 1 together.
  - After NUM_OPS edges -> FLUSH.
- FLUSH: wr_en=0, rd_en=1 until empty=1 sampled -> DONE. Limit is FIFO_DEPTH+4 edges, else timeout_err.
- DONE: wr_en=rd_en=0; done=1, busy=0. Leaves DONE only on reset.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every edge while busy. For FIFO_WIDTH>16, data_in concatenates successive LFSR values (replicated, truncated to width).
- Counters: wr_count increments on wr_ack=1; rd_count increments on rd_en&~empty. Both saturate at 2^32-1.
- Sticky flags set on any cycle where the corresponding input is 1; cleared only by reset.
- Reset mid-operation: immediate return to IDLE; counters and sticky flags cleared.

Optional Feature:
- Macro: FIFO_GEN_DATA_CHECK_EN
- With macro:
  - wr_sum accumulates data_in (XOR) on each wr_ack=1.
  - A read accepted at edge k registers a one-cycle capture flag; data_out is XORed into rd_sum at edge k+1.
  - On entry to DONE, one edge after the final capture, chk_err<=(wr_sum!=rd_sum).
- Without macro: data_out is unused; chk_err is tied to 0; no accumulators.

Decomposition:
- Package fifo_gen_pkg: state enum gen_state_e; LFSR_TAPS constant; default thresholds; TIMEOUT_MARGIN=4.
- Sub-module fifo_gen_lfsr: 16-bit Galois LFSR with enable, seed parameter, async active-low reset. Instantiated once.

Test Plan (against a reference FIFO, FIFO_DEPTH=8, FIFO_WIDTH=16):
- Reset then start pulse -> busy=1 next cycle; exactly 8 wr_ack pulses in FILL; ovf_seen=1; state DRAIN within 10 cycles of start.
- DRAIN from full -> rd_count=8 at RANDOM entry; udf_seen=1; wr_en=0 throughout DRAIN.
- Full run, NUM_OPS=1000 -> done=1; final wr_count==rd_count; timeout_err=0; with macro, chk_err=0.
- Bench forces full=0 for the whole run -> timeout_err=1 after 13 FILL cycles; done=1; wr_en=0.
- Assert rst_n low mid-RANDOM -> all outputs 0 in the same cycle; a new start repeats FILL with an identical data_in sequence (seed 16'hACE1).
- With macro, corrupt one data_out bit during FLUSH -> chk_err=1 at DONE.
